// File: rtl/clk_div_monitor_pkg.sv
// Shared types for the divided-clock monitor and the CSR/debug block that reads it.
package clk_div_monitor_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } mon_state_t;

  // Error cause encoding used by the CSR block when it logs err pulses
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_cause_t;

  // Width of the saturating error counter
  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/clk_div_monitor_edge_det.sv
// Registered edge detector for a signal already synchronous to clk.
// Reusable by other monitors that need single-cycle rise/fall strobes.
module edge_det
  import clk_div_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic prev_in;

  // Previous-cycle copy of the input; tracks din even while the monitor is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_in <= 1'b0;
    end else begin
      prev_in <= din;
    end
  end

  assign rise = din & ~prev_in;
  assign fall = ~din & prev_in;

endmodule

// File: rtl/clk_div_monitor.sv
// Built-in self-check for an FSM clock divider: measures high time and period
// of div_in in clk cycles, flags mismatches and timeouts, and reports lock.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int DIV      = 4,
  parameter int HIGH_CYC = 1,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 div_in,
  output logic [CNT_W-1:0]     period_o,
  output logic [CNT_W-1:0]     high_o,
  output logic                 meas_vld,
  output logic                 err,
  output logic                 timeout,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int                   GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]     DIV_C   = CNT_W'(DIV);
  localparam logic [CNT_W-1:0]     HIGH_C  = CNT_W'(HIGH_CYC);
  localparam logic [GOOD_W-1:0]    LOCK_G  = GOOD_W'(LOCK_CNT);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  // High + low summed one bit wider, then clamped to the counter range
  function automatic logic [CNT_W-1:0] sat_sum(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // Error counter sticks at its maximum instead of wrapping
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

  mon_state_t        state;
  logic [CNT_W-1:0]  hcnt;
  logic [CNT_W-1:0]  lcnt;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_inc;
  logic [CNT_W-1:0]  meas_period;
  logic              meas_good;
  logic              rise;
  logic              fall;
  logic              to_hit;

  edge_det u_edge_det (
    .clk  (clk),
    .rst  (rst),
    .din  (div_in),
    .rise (rise),
    .fall (fall)
  );

  assign meas_period = sat_sum(hcnt, lcnt);
  assign meas_good   = (meas_period == DIV_C) && (hcnt == HIGH_C);
  assign good_inc    = (good_cnt == LOCK_G) ? good_cnt : good_cnt + 1'b1;

  // A counter already at its maximum with no edge this cycle cannot count further.
  // In HIGH the input is 1 whenever there is no fall; in LOW it is 0 whenever there is no rise.
  assign to_hit = ((state == HIGH) && !fall && (hcnt == CNT_MAX)) ||
                  ((state == LOW)  && !rise && (lcnt == CNT_MAX));

  // Monitor FSM: high/low counting, measurement registers, checker and lock tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      lcnt     <= '0;
      good_cnt <= '0;
      period_o <= '0;
      high_o   <= '0;
      meas_vld <= 1'b0;
      err      <= 1'b0;
      timeout  <= 1'b0;
      locked   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      meas_vld <= 1'b0;
      err      <= 1'b0;
      timeout  <= 1'b0;
      if (!en) begin
        // Disable wins over any same-cycle edge or timeout; measurement results and err_cnt hold
        state    <= IDLE;
        hcnt     <= '0;
        lcnt     <= '0;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else if (to_hit) begin
        // Stuck input: report, drop lock and resynchronise on the next rise
        state    <= SYNC;
        hcnt     <= '0;
        lcnt     <= '0;
        good_cnt <= '0;
        locked   <= 1'b0;
        err      <= 1'b1;
        timeout  <= 1'b1;
        err_cnt  <= sat_inc(err_cnt);
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            // The partial period in progress at enable is discarded
            if (rise) begin
              state <= HIGH;
              hcnt  <= CNT_ONE;
              lcnt  <= '0;
            end
          end
          HIGH: begin
            if (fall) begin
              state <= LOW;
              lcnt  <= CNT_ONE;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
          LOW: begin
            if (rise) begin
              // End of one full period; the rise cycle is the first high cycle of the next one
              period_o <= meas_period;
              high_o   <= hcnt;
              meas_vld <= 1'b1;
              err      <= !meas_good;
              state    <= HIGH;
              hcnt     <= CNT_ONE;
              lcnt     <= '0;
              if (meas_good) begin
                good_cnt <= good_inc;
                locked   <= (good_inc == LOCK_G);
              end else begin
                good_cnt <= '0;
                locked   <= 1'b0;
                err_cnt  <= sat_inc(err_cnt);
              end
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomised and directed stimulus for clk_div_monitor, checked by a scoreboard
// fed from a behavioural model that works on run lengths of div_in.
module tb_clk_div_monitor;

  localparam int DIV      = 4;
  localparam int HIGH_CYC = 1;
  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 3;
  localparam int CMAX     = 255;
  localparam int EMAX     = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             div_in;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             meas_vld;
  logic             err;
  logic             timeout;
  logic             locked;
  logic [7:0]       err_cnt;

  clk_div_monitor #(
    .DIV      (DIV),
    .HIGH_CYC (HIGH_CYC),
    .CNT_W    (CNT_W),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .period_o (period_o),
    .high_o   (high_o),
    .meas_vld (meas_vld),
    .err      (err),
    .timeout  (timeout),
    .locked   (locked),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stamp;
    bit meas;
    bit er;
    bit to;
    int period;
    int high;
    bit lck;
    int ecnt;
  } ev_t;

  ev_t evq[$];
  ev_t mon_e;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state: phase 0 = disabled, 1 = waiting for a rise, 2 = measuring
  int m_phase = 0;
  int m_ones = 0;
  int m_zeros = 0;
  int m_run = 0;
  int m_ecnt = 0;
  int m_period = 0;
  int m_high = 0;
  bit m_locked = 0;
  bit m_prev = 0;

  // Model values aligned to the clock edge at which the DUT should show them
  int x_locked = 0;
  int x_ecnt = 0;
  int x_period = 0;
  int x_high = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mdl_reset();
    m_phase = 0; m_ones = 0; m_zeros = 0; m_run = 0; m_ecnt = 0;
    m_period = 0; m_high = 0; m_locked = 0; m_prev = 0;
  endtask

  task automatic push_ev(input bit meas, input bit er, input bit to);
    ev_t e;
    e.stamp = cyc + 1; e.meas = meas; e.er = er; e.to = to;
    e.period = m_period; e.high = m_high; e.lck = m_locked; e.ecnt = m_ecnt;
    evq.push_back(e);
  endtask

  // One clk sample of (en, div_in) as the DUT will see it at the next rising edge
  task automatic mdl_step(input bit e, input bit d);
    bit r;
    int p;
    bit good;
    r = d && !m_prev;
    m_prev = d;
    if (!e) begin
      m_phase = 0; m_ones = 0; m_zeros = 0; m_run = 0; m_locked = 0;
      return;
    end
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (r) begin m_phase = 2; m_ones = 1; m_zeros = 0; end
    end else if (r) begin
      p = m_ones + m_zeros;
      if (p > CMAX) p = CMAX;
      good = (p == DIV) && (m_ones == HIGH_CYC);
      m_period = p;
      m_high = m_ones;
      if (good) begin
        m_run = (m_run < LOCK_CNT) ? m_run + 1 : LOCK_CNT;
        m_locked = (m_run == LOCK_CNT);
      end else begin
        m_run = 0; m_locked = 0;
        m_ecnt = (m_ecnt < EMAX) ? m_ecnt + 1 : EMAX;
      end
      push_ev(1'b1, !good, 1'b0);
      m_ones = 1; m_zeros = 0;
    end else if ((d && m_ones == CMAX) || (!d && m_zeros == CMAX)) begin
      m_run = 0; m_locked = 0;
      m_ecnt = (m_ecnt < EMAX) ? m_ecnt + 1 : EMAX;
      push_ev(1'b0, 1'b1, 1'b1);
      m_phase = 1; m_ones = 0; m_zeros = 0;
    end else if (d) begin
      m_ones++;
    end else begin
      m_zeros++;
    end
  endtask

  task automatic drive(input bit e, input bit d);
    @(posedge clk); #1;
    rst = 1'b0; en = e; div_in = d;
    mdl_step(e, d);
  endtask

  // Holds rst for n rising edges; the next drive releases it
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; div_in = 1'b0;
    mdl_reset();
    evq.delete();
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic run_pat(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < h; i++) drive(1'b1, 1'b1);
      for (int i = 0; i < l; i++) drive(1'b1, 1'b0);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    x_locked <= int'(m_locked);
    x_ecnt   <= m_ecnt;
    x_period <= m_period;
    x_high   <= m_high;
  end

  // Monitor: level outputs every cycle, pulses matched against the scoreboard queue
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs",
          int'({period_o, high_o, meas_vld, err, timeout, locked, err_cnt}), 0);
    end else begin
      chk("locked", int'(locked), x_locked);
      chk("err_cnt", int'(err_cnt), x_ecnt);
      chk("period_o", int'(period_o), x_period);
      chk("high_o", int'(high_o), x_high);
      if (meas_vld || err || timeout) begin
        if (evq.size() == 0) begin
          chk("unexpected_pulse", int'({meas_vld, err, timeout}), 0);
        end else begin
          mon_e = evq.pop_front();
          chk("pulse_cycle", cyc, mon_e.stamp);
          chk("meas_vld", int'(meas_vld), int'(mon_e.meas));
          chk("err", int'(err), int'(mon_e.er));
          chk("timeout", int'(timeout), int'(mon_e.to));
          chk("pulse_locked", int'(locked), int'(mon_e.lck));
          chk("pulse_err_cnt", int'(err_cnt), mon_e.ecnt);
          if (mon_e.meas) begin
            chk("meas_period", int'(period_o), mon_e.period);
            chk("meas_high", int'(high_o), mon_e.high);
          end
        end
      end else if (evq.size() > 0 && evq[0].stamp <= cyc) begin
        mon_e = evq.pop_front();
        chk("missed_pulse", 0, int'({mon_e.meas, mon_e.er, mon_e.to}));
      end
    end
  end

  initial begin
    int h;
    int l;
    bit e;
    rst = 1'b1; en = 1'b0; div_in = 1'b0;
    do_reset(3);

    // Correct divider locks
    run_pat(1, 3, 6);
    chk("locked_after_lock", int'(locked), 1);

    // Input stuck low after lock
    repeat (270) drive(1'b1, 1'b0);
    chk("locked_after_stuck_low", int'(locked), 0);
    chk("err_cnt_after_stuck_low", int'(err_cnt), 1);
    run_pat(1, 3, 5);
    chk("relock_after_timeout", int'(locked), 1);

    // Enable dropped while in HIGH
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    run_pat(1, 3, 5);
    chk("relock_after_en_drop", int'(locked), 1);

    // Reset while locked and in LOW
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    do_reset(1);
    run_pat(1, 3, 5);
    chk("relock_after_reset", int'(locked), 1);

    // Wrong duty cycle, then enough mismatches to saturate err_cnt
    run_pat(2, 2, 6);
    chk("locked_wrong_duty", int'(locked), 0);
    run_pat(2, 2, 256);
    chk("err_cnt_saturated", int'(err_cnt), 255);

    // Period longer than the counter range, then input stuck high
    run_pat(200, 100, 2);
    repeat (260) drive(1'b1, 1'b1);

    // Random duty/period with occasional enable drops and resets
    for (int k = 0; k < 60; k++) begin
      h = $urandom_range(1, 3);
      l = $urandom_range(1, 5);
      if ($urandom_range(0, 2) == 0) begin
        h = HIGH_CYC;
        l = DIV - HIGH_CYC;
      end
      for (int i = 0; i < h; i++) begin
        e = ($urandom_range(0, 24) != 0);
        drive(e, 1'b1);
      end
      for (int i = 0; i < l; i++) begin
        e = ($urandom_range(0, 24) != 0);
        drive(e, 1'b0);
      end
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 2));
    end

    repeat (4) drive(1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("leftover_events", evq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
